vedic_16bit_iter: RTL and testbench

- Iterative 16x16 unsigned multiplier built around one instance of the combinational vedic_8bit core (8x8 -> 16).
- Splits each operand into 8-bit halves and feeds the four half-products through the shared core, one per cycle.
- Shifts and accumulates the half-products into a 32-bit result.
- Valid/ready handshake on both sides, so it drops into a streaming datapath in front of downstream consumers.

---
 rtl/vedic_16bit_iter.sv | 119 +++++++++++
 tb/tb_vedic_16bit_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vedic_16bit_iter.sv
// vedic_16bit_iter: iterative 16x16 multiplier reusing one 8x8 vedic core.
// The four half-products go through the core one per cycle and are
// shift-accumulated into a 32-bit sum. Valid/ready handshake on both sides.
// Optional macro VEDIC_SIGNED_EN: operands are two's complement. The core
// multiplies magnitudes, and the sign is applied when the result is latched.
// CLR_OUT = 1 forces p to zero whenever out_valid is low.

module vedic_8bit (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    // Vertical-and-crosswise split into four 4x4 nibble products
    logic [7:0] ll, lh, hl, hh;

    assign ll  = {4'b0, a_i[3:0]} * {4'b0, b_i[3:0]};
    assign lh  = {4'b0, a_i[3:0]} * {4'b0, b_i[7:4]};
    assign hl  = {4'b0, a_i[7:4]} * {4'b0, b_i[3:0]};
    assign hh  = {4'b0, a_i[7:4]} * {4'b0, b_i[7:4]};
    assign p_o = {8'b0, ll} + ({8'b0, lh} << 4) + ({8'b0, hl} << 4) + {hh, 8'b0};
endmodule

module vedic_16bit_iter #(
    parameter bit CLR_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q;
    logic [1:0]  step_q;
    logic [31:0] acc_q, acc_d, p_q, res_d;
    logic [15:0] a_q, b_q, a_op_d, b_op_d;
    logic [7:0]  core_a, core_b;
    logic [15:0] core_p;
    logic [4:0]  shift;

    // step bit 0 picks the high byte of a, step bit 1 the high byte of b
    assign core_a = step_q[0] ? a_q[15:8] : a_q[7:0];
    assign core_b = step_q[1] ? b_q[15:8] : b_q[7:0];
    // weight of the half-product: 0, 8, 8, 16
    assign shift  = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 3'b000};

    vedic_8bit u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

    // zero-extended shifted partial product; the sum never exceeds 0xFFFE0001
    assign acc_d = acc_q + ({16'b0, core_p} << shift);

`ifdef VEDIC_SIGNED_EN
    logic sign_q;

    // Magnitudes feed the unsigned datapath; 0x8000 maps to 32768
    assign a_op_d = a[15] ? (~a + 16'd1) : a;
    assign b_op_d = b[15] ? (~b + 16'd1) : b;
    assign res_d  = sign_q ? (~acc_d + 32'd1) : acc_d;

    // Product sign captured alongside the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sign_q <= 1'b0;
        else if (state_q == IDLE && in_valid)
            sign_q <= a[15] ^ b[15];
    end
`else
    assign a_op_d = a;
    assign b_op_d = b;
    assign res_d  = acc_d;
`endif

    // Control FSM plus operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= 32'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            p_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a_op_d;
                    b_q     <= b_op_d;
                    acc_q   <= 32'd0;
                    step_q  <= 2'd0;
                    state_q <= MUL;
                end
                MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        p_q     <= res_d;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = (CLR_OUT && state_q != DONE) ? 32'd0 : p_q;
endmodule

// File: tb/tb_vedic_16bit_iter.sv
// Self-checking bench for vedic_16bit_iter: directed corner products,
// backpressure, mid-operation reset and a randomized stream, all checked
// against a plain-arithmetic product model.

module tb_vedic_16bit_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] p;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    vedic_16bit_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SIGNED_EN
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return 32'(sx * sy);
`else
        longint ux, uy;
        ux = x;
        uy = y;
        return 32'(ux * uy);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and step past the accepting edge; scrambles a/b after
    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        int n;
        in_valid = 1'b1;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Wait for the product, check latency and value, optionally stall the consumer
    task automatic result(input string tag, input logic [31:0] exp, input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_p"}, p, exp);
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 16'h0002;
            b = 16'h0003;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_p"}, p, exp);
                chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        chk({tag, "_taken"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_keep_p"}, p, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x, y;
        int last;

        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_p", p, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        accept(16'h1234, 16'h5678);
        chk("first_busy", 32'(busy), 32'd1);
        result("t1234", 32'h06260060, 0);
        accept(16'hFFFF, 16'hFFFF); result("tmax", model(16'hFFFF, 16'hFFFF), 0);
        accept(16'h00FF, 16'h00FF); result("tff", 32'h0000FE01, 0);
        accept(16'h0000, 16'hABCD); result("tzero", 32'd0, 0);

        // Backpressure: 0x0100^2 held three cycles, 2*3 must not sneak in
        accept(16'h0100, 16'h0100); result("tbp", 32'h00010000, 3);
        accept(16'h0002, 16'h0003); result("t2x3", 32'h00000006, 0);

        // Reset while step 2 is in flight
        accept(16'hFFFF, 16'h0002);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_p", p, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        accept(16'd3, 16'd5); result("t3x5", 32'h0000000F, 0);

`ifdef VEDIC_SIGNED_EN
        accept(16'hFFFF, 16'h0002); result("s_m1x2", 32'hFFFFFFFE, 0);
        accept(16'h8000, 16'h8000); result("s_minsq", 32'h40000000, 0);
        accept(16'h8000, 16'h0001); result("s_minx1", 32'hFFFF8000, 0);
        accept(16'h7FFF, 16'hFFFF); result("s_maxxm1", 32'hFFFF8001, 0);
`endif

        // Streaming with the consumer always ready
        last = -100;
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            in_valid = 1'b1;
            a = x;
            b = y;
            accept(x, y);
            if (i > 0) chk("stream_gap_ge5", 32'(cyc - last >= 5), 32'd1);
            last = cyc;
            result("stream", model(x, y), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
